// File: rtl/ds_cic_decimator.sv
// ds_cic_decimator: multi-channel sinc^N decimator for 1-bit
// delta-sigma streams, with valid/ready output and overrun flag.
module ds_cic_decimator #(
  parameter int NCH       = 2,
  parameter int ORDER     = 2,
  parameter int DECIM     = 16,
  parameter int SHIFT     = 0,
  parameter int OUT_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [NCH-1:0]           bit_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [NCH*OUT_WIDTH-1:0] dig_out,
  output logic                     overrun
);

  localparam int LD = $clog2(DECIM);
  localparam int AW = ORDER*LD + 2;
  localparam int EW = (AW > OUT_WIDTH) ? AW : OUT_WIDTH;

  localparam logic signed [AW-1:0] P_ONE =
    {{(AW-1){1'b0}}, 1'b1};
  localparam logic signed [AW-1:0] M_ONE = '1;

  localparam logic signed [EW-1:0] SMAX =
    {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN =
    {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [AW-1:0] integ_q [NCH][ORDER];
  logic signed [AW-1:0] integ_d [NCH][ORDER];
  logic signed [AW-1:0] snap_q  [NCH];
  logic signed [AW-1:0] dly_q   [NCH][ORDER];
  logic signed [AW-1:0] cin_d   [NCH][ORDER];
  logic signed [AW-1:0] comb_y  [NCH];

  logic [LD-1:0]            cnt_q;
  logic                     dec_edge;
  logic                     pend_q;
  logic [NCH*OUT_WIDTH-1:0] dig_d;

  assign dec_edge = in_valid && (&cnt_q);

  // next integrator values: stage k adds post-update stage k-1
  always_comb begin
    logic signed [AW-1:0] run;
    for (int c = 0; c < NCH; c++) begin
      run = bit_in[c] ? P_ONE : M_ONE;
      for (int k = 0; k < ORDER; k++) begin
        run = integ_q[c][k] + run;
        integ_d[c][k] = run;
      end
    end
  end

  // integrators and decimation counter advance on strobes only
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < ORDER; k++)
          integ_q[c][k] <= '0;
    end else if (in_valid) begin
      cnt_q <= cnt_q + LD'(1);
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < ORDER; k++)
          integ_q[c][k] <= integ_d[c][k];
    end
  end

  // snapshot last integrator on the decimation edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      for (int c = 0; c < NCH; c++)
        snap_q[c] <= '0;
    end else begin
      pend_q <= dec_edge;
      if (dec_edge)
        for (int c = 0; c < NCH; c++)
          snap_q[c] <= integ_d[c][ORDER-1];
    end
  end

  // comb chain: each stage subtracts its delayed input
  always_comb begin
    logic signed [AW-1:0] run;
    for (int c = 0; c < NCH; c++) begin
      run = snap_q[c];
      for (int k = 0; k < ORDER; k++) begin
        cin_d[c][k] = run;
        run = run - dly_q[c][k];
      end
      comb_y[c] = run;
    end
  end

  // comb delays load once, the cycle after decimation
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < ORDER; k++)
          dly_q[c][k] <= '0;
    end else if (pend_q) begin
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < ORDER; k++)
          dly_q[c][k] <= cin_d[c][k];
    end
  end

  // shift, saturate and pack every channel
  always_comb begin
    logic signed [AW-1:0] sh;
    logic signed [EW-1:0] ext;
    logic [OUT_WIDTH-1:0] y;
    dig_d = '0;
    for (int c = 0; c < NCH; c++) begin
      sh  = comb_y[c] >>> SHIFT;
      ext = EW'(sh);
      unique case (1'b1)
        (ext > SMAX): y = SMAX[OUT_WIDTH-1:0];
        (ext < SMIN): y = SMIN[OUT_WIDTH-1:0];
        default:      y = ext[OUT_WIDTH-1:0];
      endcase
      dig_d[c*OUT_WIDTH +: OUT_WIDTH] = y;
    end
  end

  // output register, handshake and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dig_out   <= '0;
      overrun   <= 1'b0;
    end else if (pend_q) begin
      out_valid <= 1'b1;
      dig_out   <= dig_d;
      if (out_valid && !out_ready)
        overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ds_cic_decimator.sv
// tb_ds_cic_decimator: directed bench with output scoreboards
// for the default build and two 8-bit saturating builds.
module tb_ds_cic_decimator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  bit_in;
  logic        out_ready;

  logic        v0, v1, v2;
  logic [19:0] d0;
  logic [15:0] d1, d2;
  logic        ovr0, ovr1, ovr2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int last0 = -1;
  int period = 0;
  int vcnt0 = 0;
  logic en_main = 1'b0;
  logic en_sat  = 1'b0;

  logic [19:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic [19:0] e0;
  logic [15:0] e1, e2;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ds_cic_decimator u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .bit_in(bit_in), .out_ready(out_ready),
    .out_valid(v0), .dig_out(d0), .overrun(ovr0)
  );

  ds_cic_decimator #(.OUT_WIDTH(8), .SHIFT(0)) u_sat0 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .bit_in(bit_in), .out_ready(out_ready),
    .out_valid(v1), .dig_out(d1), .overrun(ovr1)
  );

  ds_cic_decimator #(.OUT_WIDTH(8), .SHIFT(2)) u_sat2 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .bit_in(bit_in), .out_ready(out_ready),
    .out_valid(v2), .dig_out(d2), .overrun(ovr2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] w10(input int a, input int b);
    return {b[9:0], a[9:0]};
  endfunction

  function automatic logic [15:0] w8(input int a, input int b);
    return {b[7:0], a[7:0]};
  endfunction

  // main scoreboard: pop on every accepted word
  always @(negedge clk) begin
    if (en_main && !rst) begin
      if (v0) vcnt0++;
      if (v0 && out_ready) begin
        chk("main_expected", 32'(q0.size() != 0), 1);
        if (q0.size() != 0) begin
          e0 = q0.pop_front();
          chk("main_data", 32'(d0), 32'(e0));
        end
        if (last0 >= 0 && period > 0)
          chk("main_period", 32'(cyc - last0), 32'(period));
        last0 = cyc;
      end
    end
  end

  // saturating builds scoreboard
  always @(negedge clk) begin
    if (en_sat && !rst) begin
      if (v1 && out_ready) begin
        chk("sat0_expected", 32'(q1.size() != 0), 1);
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          chk("sat0_data", 32'(d1), 32'(e1));
        end
      end
      if (v2 && out_ready) begin
        chk("sat2_expected", 32'(q2.size() != 0), 1);
        if (q2.size() != 0) begin
          e2 = q2.pop_front();
          chk("sat2_data", 32'(d2), 32'(e2));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    last0 = -1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q0.size() + q1.size() + q2.size() == 0) break;
      tick();
    end
    tick();
    chk("q_main_empty", 32'(q0.size()), 0);
    chk("q_sat0_empty", 32'(q1.size()), 0);
    chk("q_sat2_empty", 32'(q2.size()), 0);
  endtask

  task automatic strobe3();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    bit_in = 2'b00;
    out_ready = 1'b1;

    // reset with random strobes
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      bit_in = 2'($urandom_range(0, 3));
      tick();
      chk("rst_valid", 32'(v0), 0);
      chk("rst_data", 32'(d0), 0);
      chk("rst_overrun", 32'(ovr0), 0);
      chk("rst_sat", 32'({v1, v2, ovr1, ovr2}), 0);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("rel_valid", 32'(v0), 0);
    chk("rel_data", 32'(d0), 0);
    chk("rel_overrun", 32'(ovr0), 0);

    // constant ones, strobe every cycle
    en_main = 1'b1;
    en_sat = 1'b1;
    period = 16;
    last0 = -1;
    vcnt0 = 0;
    q0.push_back(w10(136, 136));
    q0.push_back(w10(256, 256));
    q0.push_back(w10(256, 256));
    repeat (3) q1.push_back(w8(127, 127));
    q2.push_back(w8(34, 34));
    q2.push_back(w8(64, 64));
    q2.push_back(w8(64, 64));
    bit_in = 2'b11;
    in_valid = 1'b1;
    repeat (48) tick();
    in_valid = 1'b0;
    drain();
    chk("ones_valid_cycles", 32'(vcnt0), 3);

    // alternating on ch0, zeros on ch1
    do_reset();
    q0.push_back(w10(8, -136));
    q0.push_back(w10(0, -256));
    q0.push_back(w10(0, -256));
    repeat (3) q1.push_back(w8(0, -128));
    q1.delete(0);
    q1.push_front(w8(8, -128));
    q2.push_back(w8(2, -34));
    q2.push_back(w8(0, -64));
    q2.push_back(w8(0, -64));
    for (int i = 0; i < 48; i++) begin
      bit_in = {1'b0, (i % 2 == 0)};
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    drain();

    // backpressure across two decimations
    en_main = 1'b0;
    en_sat = 1'b0;
    do_reset();
    out_ready = 1'b0;
    bit_in = 2'b11;
    in_valid = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 32) in_valid = 1'b0;
      if (i == 16) chk("bp_latency", 32'(v0), 0);
      if (i == 17) begin
        chk("bp_first_valid", 32'(v0), 1);
        chk("bp_first_data", 32'(d0), 32'(w10(136, 136)));
        chk("bp_first_ovr", 32'(ovr0), 0);
      end
      if (i == 31) begin
        chk("bp_hold_valid", 32'(v0), 1);
        chk("bp_hold_data", 32'(d0), 32'(w10(136, 136)));
        chk("bp_hold_ovr", 32'(ovr0), 0);
      end
      if (i == 33) begin
        chk("bp_over_valid", 32'(v0), 1);
        chk("bp_over_data", 32'(d0), 32'(w10(256, 256)));
        chk("bp_over_ovr", 32'(ovr0), 1);
        out_ready = 1'b1;
      end
      if (i == 34) begin
        chk("bp_consumed", 32'(v0), 0);
        chk("bp_sticky", 32'(ovr0), 1);
      end
      if (i == 40) chk("bp_sticky_late", 32'(ovr0), 1);
    end
    do_reset();
    chk("bp_rst_ovr", 32'(ovr0), 0);
    chk("bp_rst_data", 32'(d0), 0);

    // sparse strobe, then reset mid-period
    en_main = 1'b1;
    period = 48;
    last0 = -1;
    q0.push_back(w10(136, 136));
    q0.push_back(w10(256, 256));
    bit_in = 2'b11;
    for (int i = 0; i < 32; i++) strobe3();
    drain();
    repeat (5) strobe3();
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    last0 = -1;
    chk("mid_rst_valid", 32'(v0), 0);
    chk("mid_rst_data", 32'(d0), 0);
    chk("mid_rst_ovr", 32'(ovr0), 0);
    q0.push_back(w10(136, 136));
    repeat (15) strobe3();
    chk("mid_rst_early", 32'(v0), 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mid_rst_dec_edge", 32'(v0), 0);
    tick();
    chk("mid_rst_latency", 32'(v0), 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ds_cic_decimator.md
# ds_cic_decimator

Multi-channel sinc^N (CIC) decimation filter that turns 1-bit delta-sigma bitstreams into signed multi-bit samples. It is the synthesizable successor to the behavioural delta-sigma ADC model. It is parametrised in channel count, filter order, decimation ratio and output scaling, and adds a valid/ready output handshake with overrun detection. It sits directly after the modulators, in the system clock domain. Bits arrive on an oversample strobe, and decimated words go to the downstream DSP/register block.

## Interface
Parameters:
- NCH, 2: number of independent channels, 1..8.
- ORDER, 2: CIC order (integrator/comb stage count), 1..3.
- DECIM, 16: decimation ratio; power of two, 4..256.
- SHIFT, 0: arithmetic right shift applied to the comb result before saturation.
- OUT_WIDTH, 10: signed output word width per channel.
- Derived localparam AW = ORDER*log2(DECIM)+2: width of accumulators and combs.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  oversample strobe; bit_in is sampled on edges where it is 1.
- bit_in  in  NCH  modulator bits, one per channel; 1 maps to +1 and 0 maps to -1.
- out_ready  in  1  downstream accepts the current output word.
- out_valid  out  1  dig_out holds an unconsumed decimated sample.
- dig_out  out  NCH*OUT_WIDTH  signed samples; channel c occupies bits [c*OUT_WIDTH +: OUT_WIDTH].
- overrun  out  1  sticky flag: a sample was overwritten before it was consumed.

## Operation
- Mapping: each bit becomes x = +1 or -1, sign-extended to AW bits.
- Integrators: ORDER cascaded AW-bit accumulators per channel. They update only on in_valid edges. Stage 1 adds x; stage k adds the post-update value of stage k-1. Two's-complement wrap-around is intended and must not saturate.
- Decimation counter: counts in_valid edges from 0 to DECIM-1, then wraps. The edge on which it wraps is the decimation edge. On that edge a snapshot register captures the post-update value of the last integrator for every channel.
- Combs: ORDER cascaded differentiators per channel, each with an AW-bit delay register. On the cycle after the decimation edge:
  - each comb output = comb input - delay;
  - each delay register is loaded with its comb input.
- Output scaling: y = (comb output >>> SHIFT), saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Steady-state gain: constant +1 input gives +DECIM^ORDER before shift.
- Handshake:
  - A new sample loads dig_out and sets out_valid.
  - While out_valid=1 and out_ready=0, dig_out is held stable.
  - An edge with out_valid=1 and out_ready=1 consumes the word. out_valid clears on that edge unless a new sample loads on the same edge; in that case out_valid stays 1 with the new data.
  - A new sample arriving while out_valid=1 and out_ready=0 overwrites dig_out and sets overrun. overrun clears only on rst.
- No internal state changes on edges with in_valid=0, except the comb/output stage completing a pending decimation.

## Timing
- Reset values (edge with rst=1): out_valid=0, dig_out=0, overrun=0. All integrators, combs, the snapshot register and the counter are 0.
- rst has priority over in_valid, out_ready and pending decimations. A decimation in flight when rst asserts is discarded.
- The first bit after reset is counter position 0. The first decimation edge is the DECIM-th in_valid edge.
- Latency: out_valid and dig_out update on the edge one clk after the decimation edge.
- in_valid may be asserted on consecutive cycles: back-to-back strobes are legal.
- The minimum output period is DECIM clk cycles. DECIM >= 4 guarantees the comb stage is free before the next decimation edge.
- Simultaneous consume and load on the same edge: new data is visible, out_valid=1, overrun is not set.

## Test plan
- Reset values: hold rst for 5 cycles with random in_valid/bit_in -> out_valid=0, dig_out=0, overrun=0 throughout and 1 cycle after release.
- Constant ones (defaults, NCH=2, both channels all ones, in_valid every cycle, out_ready=1) -> outputs 136, 256, 256, ...
  - one output every 16 cycles;
  - out_valid high for exactly 1 cycle;
  - channel 1 identical to channel 0.
- Alternating and zero input: channel 0 alternates 1,0; channel 1 is constant 0 -> channel 0 settles to 0; channel 1 gives -136 then -256; steady state is reached from the second output onward.
- Saturation/shift: OUT_WIDTH=8, constant ones.
  - SHIFT=0 -> steady output 127.
  - SHIFT=2 -> steady output 64.
  - Constant zeros with SHIFT=0 -> steady output -128.
- Backpressure: out_ready=0 across two decimations -> first word held stable, then overwritten by the second, overrun=1 from that edge. overrun stays 1 after out_ready=1 until rst.
- Sparse strobe and mid-run reset: in_valid every 3rd cycle with constant ones -> output period 48 cycles with values 136, 256. Asserting rst 5 strobes into a decimation period -> everything cleared; the next output is 136 again, DECIM strobes after release.
